// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared constants for the VLIW register file
package vliw_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NUM_REGS    = 8;
  localparam int DEF_NUM_SLOTS   = 2;
  localparam int DEF_RD_PER_SLOT = 3;
  localparam int ZERO_REG        = 0;
  localparam int CONFLICT_CNT_W  = 8;

  // Flat read-port number for sub-port j of lane slot.
  function automatic int portIndex(input int slot, input int sub, input int rdPerSlot);
    return slot * rdPerSlot + sub;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for long-latency results
// Optional macro REGFILE_BYPASS_EN: a same-cycle write hides the busy bit on reads.
module regfile_scoreboard
  import vliw_pkg::*;
#(
  parameter  int NUM_REGS    = DEF_NUM_REGS,
  parameter  int NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter  int RD_PER_SLOT = DEF_RD_PER_SLOT,
  localparam int AW          = $clog2(NUM_REGS),
  localparam int NUM_RD      = NUM_SLOTS * RD_PER_SLOT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SLOTS-1:0]    wr_en,
  input  logic [NUM_SLOTS*AW-1:0] wr_addr,
  input  logic [NUM_SLOTS-1:0]    rsv_en,
  input  logic [NUM_SLOTS*AW-1:0] rsv_addr,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_REGS-1:0]     busy,
  output logic [NUM_RD-1:0]       rd_busy
);

  logic [NUM_REGS-1:0] setVec;
  logic [NUM_REGS-1:0] clrVec;

  always_comb begin
    setVec = '0;
    clrVec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (wr_en[i])  clrVec[wr_addr[i*AW +: AW]]  = 1'b1;
      if (rsv_en[i]) setVec[rsv_addr[i*AW +: AW]] = 1'b1;
    end
    setVec[ZERO_REG] = 1'b0;
    clrVec[ZERO_REG] = 1'b0;
  end

  // Set after clear: a reservation landing with the write keeps the register busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= (busy & ~clrVec) | setVec;
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
`ifdef REGFILE_BYPASS_EN
      if (clrVec[rd_addr[p*AW +: AW]]) rd_busy[p] = setVec[rd_addr[p*AW +: AW]];
      else                             rd_busy[p] = busy[rd_addr[p*AW +: AW]];
`else
      rd_busy[p] = busy[rd_addr[p*AW +: AW]];
`endif
    end
  end

endmodule

// File: rtl/vliw_regfile_mp.sv
// rtl/vliw_regfile_mp.sv - multi-lane VLIW register file with busy scoreboard
// Optional macro REGFILE_BYPASS_EN: same-cycle write data forwarded to reads.
module vliw_regfile_mp
  import vliw_pkg::*;
#(
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int NUM_REGS    = DEF_NUM_REGS,
  parameter  int NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter  int RD_PER_SLOT = DEF_RD_PER_SLOT,
  localparam int AW          = $clog2(NUM_REGS),
  localparam int NUM_RD      = NUM_SLOTS * RD_PER_SLOT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SLOTS-1:0]         wr_en,
  input  logic [NUM_SLOTS*AW-1:0]      wr_addr,
  input  logic [NUM_SLOTS*DATA_W-1:0]  wr_data,
  input  logic [NUM_RD*AW-1:0]         rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  input  logic [NUM_SLOTS-1:0]         rsv_en,
  input  logic [NUM_SLOTS*AW-1:0]      rsv_addr,
  output logic [NUM_REGS-1:0]          busy,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic                        wr_conflict,
  output logic [CONFLICT_CNT_W-1:0]    conflict_cnt
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

  logic [DATA_W-1:0]   regArr  [NUM_REGS];
  logic [DATA_W-1:0]   winData [NUM_REGS];
  logic [NUM_REGS-1:0] winEn;
  logic                conflictNow;

  // Walk lanes high to low so the lowest enabled lane leaves the final value.
  always_comb begin
    winEn = '0;
    for (int r = 0; r < NUM_REGS; r++) winData[r] = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (wr_en[i] && (wr_addr[i*AW +: AW] != ZeroAddr)) begin
        winEn[wr_addr[i*AW +: AW]]   = 1'b1;
        winData[wr_addr[i*AW +: AW]] = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    conflictNow = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int k = i + 1; k < NUM_SLOTS; k++) begin
        if (wr_en[i] && wr_en[k] && (wr_addr[i*AW +: AW] == wr_addr[k*AW +: AW]) &&
            (wr_addr[i*AW +: AW] != ZeroAddr))
          conflictNow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) regArr[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (winEn[r]) regArr[r] <= winData[r];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_conflict  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      wr_conflict <= conflictNow;
      if (conflictNow && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  // Reset gating keeps forwarded write data off the outputs while reset is held.
  always_comb begin
    rd_data = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int j = 0; j < RD_PER_SLOT; j++) begin
        rd_data[portIndex(s, j, RD_PER_SLOT)*DATA_W +: DATA_W] =
          regArr[rd_addr[portIndex(s, j, RD_PER_SLOT)*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (winEn[rd_addr[portIndex(s, j, RD_PER_SLOT)*AW +: AW]])
          rd_data[portIndex(s, j, RD_PER_SLOT)*DATA_W +: DATA_W] =
            winData[rd_addr[portIndex(s, j, RD_PER_SLOT)*AW +: AW]];
`endif
        if (!reset || (rd_addr[portIndex(s, j, RD_PER_SLOT)*AW +: AW] == ZeroAddr))
          rd_data[portIndex(s, j, RD_PER_SLOT)*DATA_W +: DATA_W] = '0;
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS    (NUM_REGS),
    .NUM_SLOTS   (NUM_SLOTS),
    .RD_PER_SLOT (RD_PER_SLOT)
  ) uScoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_vliw_regfile_mp.sv
// tb/tb_vliw_regfile_mp.sv - scoreboard bench for vliw_regfile_mp (honours REGFILE_BYPASS_EN)
module tb_vliw_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int NS = 2;
  localparam int RPS = 3;
  localparam int AW = 3;
  localparam int NP = NS * RPS;

  typedef struct {
    logic [NP*DW-1:0] rd;
    logic [NP-1:0]    rb;
    logic [NR-1:0]    bz;
    logic             wc;
    logic [7:0]       cnt;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NS-1:0]    wrEn = '0;
  logic [NS*AW-1:0] wrAddr = '0;
  logic [NS*DW-1:0] wrData = '0;
  logic [NP*AW-1:0] rdAddr = '0;
  logic [NS-1:0]    rsvEn = '0;
  logic [NS*AW-1:0] rsvAddr = '0;
  logic [NP*DW-1:0] rdData;
  logic [NR-1:0]    busy;
  logic [NP-1:0]    rdBusy;
  logic             wrConflict;
  logic [7:0]       conflictCnt;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mReg[NR];
  logic [NR-1:0] mBusy;
  logic          mWc;
  int            mCnt;

  vliw_regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_SLOTS(NS), .RD_PER_SLOT(RPS)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_addr(rdAddr), .rd_data(rdData),
    .rsv_en(rsvEn), .rsv_addr(rsvAddr),
    .busy(busy), .rd_busy(rdBusy),
    .wr_conflict(wrConflict), .conflict_cnt(conflictCnt)
  );

  always #5 clk = ~clk;

  task automatic modelClear();
    for (int r = 0; r < NR; r++) mReg[r] = '0;
    mBusy = '0;
    mWc = 1'b0;
    mCnt = 0;
  endtask

  // Expected outputs for the inputs now applied, from the architectural state.
  function automatic exp_t expectNow(input string tag);
    exp_t e;
    e.tag = tag;
    e.bz = mBusy;
    e.wc = mWc;
    e.cnt = 8'(mCnt);
    e.rd = '0;
    e.rb = '0;
    for (int p = 0; p < NP; p++) begin
      int a;
      logic [DW-1:0] v;
      logic b;
      a = int'(rdAddr[p*AW +: AW]);
      v = (a == 0 || !reset) ? '0 : mReg[a];
      b = mBusy[a];
`ifdef REGFILE_BYPASS_EN
      if (a != 0 && reset) begin
        bit hit;
        bit rsv;
        hit = 0;
        rsv = 0;
        for (int i = 0; i < NS; i++)
          if (rsvEn[i] && int'(rsvAddr[i*AW +: AW]) == a) rsv = 1;
        for (int i = NS - 1; i >= 0; i--)
          if (wrEn[i] && int'(wrAddr[i*AW +: AW]) == a) begin
            hit = 1;
            v = wrData[i*DW +: DW];
          end
        if (hit) b = rsv;
      end
`endif
      e.rd[p*DW +: DW] = v;
      e.rb[p] = b;
    end
    return e;
  endfunction

  task automatic modelEdge();
    bit conflict;
    conflict = 0;
    for (int a = 1; a < NR; a++) begin
      int n;
      n = 0;
      for (int i = 0; i < NS; i++)
        if (wrEn[i] && int'(wrAddr[i*AW +: AW]) == a) n++;
      if (n >= 2) conflict = 1;
    end
    for (int i = NS - 1; i >= 0; i--)
      if (wrEn[i] && wrAddr[i*AW +: AW] != 0) mReg[wrAddr[i*AW +: AW]] = wrData[i*DW +: DW];
    for (int i = 0; i < NS; i++)
      if (wrEn[i]) mBusy[wrAddr[i*AW +: AW]] = 1'b0;
    for (int i = 0; i < NS; i++)
      if (rsvEn[i]) mBusy[rsvAddr[i*AW +: AW]] = 1'b1;
    mBusy[0] = 1'b0;
    mWc = conflict;
    if (conflict && mCnt < 255) mCnt++;
  endtask

  task automatic drive(input logic [NS-1:0] we, input logic [NS*AW-1:0] wa,
                       input logic [NS*DW-1:0] wd, input logic [NS-1:0] re,
                       input logic [NS*AW-1:0] ra, input logic [NP*AW-1:0] rda,
                       input string tag);
    @(negedge clk);
    wrEn = we; wrAddr = wa; wrData = wd; rsvEn = re; rsvAddr = ra; rdAddr = rda;
    expQ.push_back(expectNow(tag));
    @(posedge clk);
    if (reset) modelEdge();
  endtask

  function automatic logic [NP*AW-1:0] allRd(input logic [AW-1:0] a);
    return {NP{a}};
  endfunction

  task automatic idle(input logic [AW-1:0] a, input string tag);
    drive('0, '0, '0, '0, '0, allRd(a), tag);
  endtask

  // Monitor: every cycle the DUT presents combinational and registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (rdData !== e.rd) begin
          errors++;
          $display("FAIL %s rd_data got %h want %h", e.tag, rdData, e.rd);
        end
        checks++;
        if (rdBusy !== e.rb) begin
          errors++;
          $display("FAIL %s rd_busy got %b want %b", e.tag, rdBusy, e.rb);
        end
        checks++;
        if (busy !== e.bz) begin
          errors++;
          $display("FAIL %s busy got %b want %b", e.tag, busy, e.bz);
        end
        checks++;
        if (wrConflict !== e.wc) begin
          errors++;
          $display("FAIL %s wr_conflict got %b want %b", e.tag, wrConflict, e.wc);
        end
        checks++;
        if (conflictCnt !== e.cnt) begin
          errors++;
          $display("FAIL %s conflict_cnt got %0d want %0d", e.tag, conflictCnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    modelClear();
    drive('0, '0, '0, '0, '0, allRd(3'd3), "reset_held");
    #1 reset = 1'b1;

    drive(2'b01, {3'd0, 3'd3}, {32'd0, 32'h0000_00AA}, '0, '0, allRd(3'd3), "wr_r3");
    idle(3'd3, "rd_r3");

    drive(2'b11, {3'd5, 3'd5}, {32'h22, 32'h11}, '0, '0, allRd(3'd5), "conflict_r5");
    idle(3'd5, "conflict_after");
    idle(3'd5, "conflict_clear");
    for (int n = 0; n < 300; n++)
      drive(2'b11, {3'd5, 3'd5}, {$urandom(), $urandom()}, '0, '0, allRd(3'd5), "conflict_rep");
    idle(3'd5, "conflict_sat");

    drive(2'b11, {3'd0, 3'd0}, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 2'b11, {3'd0, 3'd0},
          allRd(3'd0), "wr_rsv_r0");
    idle(3'd0, "r0_after");

    drive('0, '0, '0, 2'b10, {3'd4, 3'd0}, allRd(3'd4), "rsv_r4");
    idle(3'd4, "r4_busy");
    drive(2'b01, {3'd0, 3'd4}, {32'd0, 32'h2A}, '0, '0, allRd(3'd4), "wr_r4");
    idle(3'd4, "r4_clear");
    drive(2'b01, {3'd0, 3'd4}, {32'd0, 32'h3B}, 2'b10, {3'd4, 3'd0}, allRd(3'd4), "rsv_wr_r4");
    idle(3'd4, "r4_rsv_wins");

    drive(2'b01, {3'd0, 3'd6}, {32'd0, 32'h33}, '0, '0, allRd(3'd6), "wr_r6_old");
    drive(2'b10, {3'd6, 3'd0}, {32'h5A, 32'd0}, '0, '0, allRd(3'd6), "bypass_r6");
    idle(3'd6, "r6_after");

    for (int n = 0; n < 400; n++) begin
      logic [NP*AW-1:0] rda;
      for (int p = 0; p < NP; p++) rda[p*AW +: AW] = 3'($urandom_range(0, NR - 1));
      drive(2'($urandom()), {3'($urandom()), 3'($urandom())}, {$urandom(), $urandom()},
            ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00,
            {3'($urandom()), 3'($urandom())}, rda, "random");
    end

    drive(2'b01, {3'd0, 3'd2}, {32'd0, 32'h0000_0077}, 2'b01, {3'd0, 3'd2}, allRd(3'd2), "pre_reset");
    #3 reset = 1'b0;
    modelClear();
    drive('0, '0, '0, '0, '0, allRd(3'd2), "reset_mid");
    #1 reset = 1'b1;
    idle(3'd2, "after_reset");
    idle(3'd2, "after_reset2");

    for (int n = 0; n < 10 && expQ.size() > 0; n++) @(negedge clk);
    @(negedge clk);
    #4;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vliw_regfile_mp.md
# vliw_regfile_mp

Parametrised multi-port register file for the VLIW datapath, generalising the fixed 8×32, two-write/six-read file to NUM_SLOTS issue lanes. Each lane gets RD_PER_SLOT read ports and one write port, with register 0 hard-wired to zero and deterministic write-conflict priority. A per-register busy scoreboard tracks results owed by long-latency operations such as mul/div, with optional same-cycle write bypass. It sits between decode (read addresses, reservations) and writeback (write ports).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 8, register count (power of two, ≥ 2)
- NUM_SLOTS, 2, issue lanes / write ports
- RD_PER_SLOT, 3, read ports per lane
- AW (localparam), clog2(NUM_REGS), address width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- wr_en  in  NUM_SLOTS  per-lane write enable
- wr_addr  in  NUM_SLOTS*AW  lane i at [i*AW +: AW]
- wr_data  in  NUM_SLOTS*DATA_W  lane i at [i*DATA_W +: DATA_W]
- rd_addr  in  NUM_SLOTS*RD_PER_SLOT*AW  port p = i*RD_PER_SLOT+j
- rd_data  out  NUM_SLOTS*RD_PER_SLOT*DATA_W  read data, same port indexing
- rsv_en  in  NUM_SLOTS  reserve (mark busy) destination of issued long-latency op
- rsv_addr  in  NUM_SLOTS*AW  register to reserve
- busy  out  NUM_REGS  scoreboard bits
- rd_busy  out  NUM_SLOTS*RD_PER_SLOT  busy[rd_addr] per read port
- wr_conflict  out  1  registered, high one cycle after a write conflict
- conflict_cnt  out  8  saturating count of conflict cycles

## Operation
- Write: at rising clk, each enabled lane updates its register. Writes to address 0 are discarded.
- Conflict: two or more enabled lanes target the same non-zero address. The lowest lane index wins; the others are dropped.
- wr_conflict is set on the next edge for each conflict cycle. conflict_cnt increments by 1 per conflict cycle (not per pair) and saturates at 255.
- Read: combinational from the array. Address 0 always returns 0.
- Scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge.
  - An enabled write clears busy[wr_addr].
  - Reservation and write to the same register in the same cycle: reservation wins, busy = 1.
  - busy[0] is constant 0; reservations of register 0 are ignored.
  - Multiple lanes reserving the same register is legal and does not count as a conflict.
- rd_busy[p] = busy[rd_addr[p]], combinational, reflecting pre-edge state.

## Timing
- Write-to-read latency: 1 cycle (value visible after the edge), unless bypass is compiled in.
- Read latency: 0 cycles (combinational).
- busy set/clear takes effect at the edge following rsv_en/wr_en.
- Reset (reset=0): asynchronously clears all registers, busy, wr_conflict and conflict_cnt to 0. All rd_data read 0 while reset is held.
- Reset asserted mid-cycle: that cycle's writes and reservations are lost. The first edge after deassertion is a normal active edge.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an enabled non-zero write in the same cycle returns the winning (lowest-lane) wr_data combinationally. rd_busy for that port reads 0 unless the same register is also being reserved.
- Not defined: reads return pre-edge array contents only, and rd_busy is the raw busy bit.

## Structure
- Shared package vliw_pkg holds:
  - DATA_W and NUM_REGS defaults
  - ZERO_REG = 0
  - CONFLICT_CNT_W = 8
  - slot-index helper constants
- One sub-module: regfile_scoreboard.
  - Contains the busy vector, reserve/clear priority and rd_busy lookup.
  - Instantiated once, parametrised by NUM_REGS, NUM_SLOTS and RD_PER_SLOT.
- The array, priority write and read muxes stay in vliw_regfile_mp.

## Test plan
- Reset with all reads at address 3 -> all rd_data 0, busy 0, conflict_cnt 0. Write lane0 r3 = 0x0000_00AA -> port 0 reads 0xAA one cycle later.
- Lane0 and lane1 both write r5 (0x11 and 0x22) -> r5 = 0x11, wr_conflict high for one cycle, conflict_cnt = 1. Repeat 300 cycles -> conflict_cnt holds at 255.
- Write r0 = 0xFFFF_FFFF and reserve r0 -> r0 reads 0, busy[0] stays 0.
- rsv_en lane1 r4 -> busy[4] = 1 and rd_busy at r4 = 1 next cycle. Write r4 = 0x2A -> busy[4] = 0. Same-cycle reserve + write to r4 -> busy[4] = 1.
- With REGFILE_BYPASS_EN: lane1 writes r6 = 0x5A while port 0 reads r6 -> rd_data = 0x5A in the same cycle. Without the macro -> old value, then 0x5A next cycle.
- Assert reset mid-cycle during a write of r2 = 0x77 -> r2 = 0 after release, and every output is at its reset value.
